// File: rtl/bank_pkg.sv
//------------------------------------------------------------------------------
// Module      : bank_pkg
// Description : Shared constants and types for the bank write path. Holds the
//               AXI3 encodings used by the writeback buffer and the writeback
//               FSM state encoding.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package bank_pkg;

   // AXI3 encodings used on the bank bus
   localparam logic [2:0] AXI_SIZE_32B   = 3'b101;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
   localparam logic [3:0] AXI_LEN_SINGLE = 4'b0000;

   // Writeback buffer FSM states (explicit 2-bit encoding)
   typedef enum logic [1:0] {
      WB_IDLE = 2'd0,
      WB_FILL = 2'd1,
      WB_SEND = 2'd2,
      WB_RESP = 2'd3
   } wb_state_t;

endpackage

`default_nettype wire

// File: rtl/bank_wb_buffer.sv
//------------------------------------------------------------------------------
// Module      : bank_wb_buffer
// Description : Single-line writeback/eviction buffer on the bank write path.
//               Accepts a line write request from the HTU, collects one or two
//               half-line beats from the SRAM controller, issues a single-beat
//               AXI3 AW+W transaction and waits for the B response.
//
// Ports       : clk_i, rst_i                 clock, async active-high reset
//               htu_wb_*                     line request (address, set/way)
//               sc_wb_*                      half-line data beats from SRAM ctrl
//               wb_axi3_aw* / w* / b*        AXI3 write channels to bank bus
//               wb_err_o                     sticky response error
//
// Config      : BANK_WB_RESP_CHECK_EN - when defined, wb_err_o latches on any
//               non-OKAY bresp or a bid that differs from the issued awid.
//               When undefined, wb_err_o is tied low.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bank_wb_buffer
   import bank_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 256,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int ID_WIDTH   = 8
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   // HTU request
   input  logic                      htu_wb_awvalid_i,
   output logic                      htu_wb_awready_o,
   input  logic [ADDR_WIDTH-6:0]     htu_wb_awaddr_i,
   input  logic [5:0]                htu_wb_set_way_i,
   // SRAM controller half-line data
   input  logic                      sc_wb_valid_i,
   output logic                      sc_wb_ready_o,
   input  logic [DATA_WIDTH/2-1:0]   sc_wb_data_i,
   input  logic                      sc_wb_offset_i,
   input  logic                      sc_wb_all_offset_i,
   input  logic [6:0]                sc_wb_set_way_offset_i,
   // AXI3 AW
   output logic                      wb_axi3_awvalid_o,
   input  logic                      wb_axi3_awready_i,
   output logic [ID_WIDTH-1:0]       wb_axi3_awid_o,
   output logic [ADDR_WIDTH-1:0]     wb_axi3_awaddr_o,
   output logic [3:0]                wb_axi3_awlen_o,
   output logic [2:0]                wb_axi3_awsize_o,
   output logic [1:0]                wb_axi3_awburst_o,
   // AXI3 W
   output logic                      wb_axi3_wvalid_o,
   input  logic                      wb_axi3_wready_i,
   output logic [ID_WIDTH-1:0]       wb_axi3_wid_o,
   output logic [DATA_WIDTH-1:0]     wb_axi3_wdata_o,
   output logic [STRB_WIDTH-1:0]     wb_axi3_wstrb_o,
   output logic                      wb_axi3_wlast_o,
   // AXI3 B
   input  logic                      wb_axi3_bvalid_i,
   output logic                      wb_axi3_bready_o,
   input  logic [ID_WIDTH-1:0]       wb_axi3_bid_i,
   input  logic [1:0]                wb_axi3_bresp_i,
   // Status
   output logic                      wb_err_o
);

   localparam int c_HALF_W    = DATA_WIDTH / 2;
   localparam int c_HALF_STRB = STRB_WIDTH / 2;
   localparam int c_LINE_W    = ADDR_WIDTH - 5;

   localparam logic [STRB_WIDTH-1:0] c_STRB_LO = {{c_HALF_STRB{1'b0}}, {c_HALF_STRB{1'b1}}};
   localparam logic [STRB_WIDTH-1:0] c_STRB_HI = {{c_HALF_STRB{1'b1}}, {c_HALF_STRB{1'b0}}};

   wb_state_t               r_state;
   wb_state_t               w_state_nxt;

   logic [c_LINE_W-1:0]     r_line_addr;
   logic [5:0]              r_set_way;
   logic [DATA_WIDTH-1:0]   r_data;
   logic [STRB_WIDTH-1:0]   r_strb;
   logic                    r_all_offset;
   logic                    r_aw_sent;
   logic                    r_w_sent;

   logic                    w_htu_accept;
   logic                    w_sc_accept;
   logic                    w_first_beat;
   logic                    w_all_offset_eff;
   logic [STRB_WIDTH-1:0]   w_strb_upd;
   logic                    w_fill_done;
   logic                    w_aw_done;
   logic                    w_w_done;
   logic [ID_WIDTH-1:0]     w_awid;

   assign w_htu_accept = (r_state == WB_IDLE) && htu_wb_awvalid_i;

   // Beats tagged with another line's set/way are stalled, never dropped
   assign w_sc_accept  = (r_state == WB_FILL) && sc_wb_valid_i &&
                         (sc_wb_set_way_offset_i[6:1] == r_set_way);

   // Strobes are cleared on request accept, so an empty strobe register in
   // FILL identifies the first beat; its all_offset decides the fill length.
   assign w_first_beat     = (r_strb == '0);
   assign w_all_offset_eff = w_first_beat ? sc_wb_all_offset_i : r_all_offset;
   assign w_strb_upd       = r_strb | (sc_wb_offset_i ? c_STRB_HI : c_STRB_LO);
   assign w_fill_done      = w_sc_accept && (!w_all_offset_eff || (&w_strb_upd));

   // In SEND each valid equals !sent, so a handshake is sent-or-ready
   assign w_aw_done = r_aw_sent || wb_axi3_awready_i;
   assign w_w_done  = r_w_sent  || wb_axi3_wready_i;

   always_comb begin
      w_awid      = '0;
      w_awid[5:0] = r_set_way;
   end

   //---------------------------------------------------------------------------
   // FSM state register
   //---------------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= WB_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   //---------------------------------------------------------------------------
   // FSM next state and handshake outputs
   //---------------------------------------------------------------------------
   always_comb begin
      w_state_nxt       = r_state;
      htu_wb_awready_o  = 1'b0;
      sc_wb_ready_o     = 1'b0;
      wb_axi3_awvalid_o = 1'b0;
      wb_axi3_wvalid_o  = 1'b0;
      wb_axi3_bready_o  = 1'b0;
      case (r_state)
         WB_IDLE: begin
            htu_wb_awready_o = 1'b1;
            if (htu_wb_awvalid_i) w_state_nxt = WB_FILL;
         end
         WB_FILL: begin
            sc_wb_ready_o = w_sc_accept;
            if (w_fill_done) w_state_nxt = WB_SEND;
         end
         WB_SEND: begin
            wb_axi3_awvalid_o = !r_aw_sent;
            wb_axi3_wvalid_o  = !r_w_sent;
            if (w_aw_done && w_w_done) w_state_nxt = WB_RESP;
         end
         WB_RESP: begin
            wb_axi3_bready_o = 1'b1;
            if (wb_axi3_bvalid_i) w_state_nxt = WB_IDLE;
         end
         default: w_state_nxt = WB_IDLE;
      endcase
   end

   //---------------------------------------------------------------------------
   // Line register, strobes and channel-sent flags
   //---------------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_line_addr  <= '0;
         r_set_way    <= '0;
         r_data       <= '0;
         r_strb       <= '0;
         r_all_offset <= 1'b0;
         r_aw_sent    <= 1'b0;
         r_w_sent     <= 1'b0;
      end else begin
         if (w_htu_accept) begin
            r_line_addr <= htu_wb_awaddr_i;
            r_set_way   <= htu_wb_set_way_i;
            r_strb      <= '0;
            r_aw_sent   <= 1'b0;
            r_w_sent    <= 1'b0;
         end
         if (w_sc_accept) begin
            // A repeated offset simply overwrites the stored half
            if (sc_wb_offset_i) begin
               r_data[DATA_WIDTH-1:c_HALF_W] <= sc_wb_data_i;
            end else begin
               r_data[c_HALF_W-1:0] <= sc_wb_data_i;
            end
            r_strb <= w_strb_upd;
            if (w_first_beat) r_all_offset <= sc_wb_all_offset_i;
         end
         if (r_state == WB_SEND) begin
            if (wb_axi3_awready_i) r_aw_sent <= 1'b1;
            if (wb_axi3_wready_i)  r_w_sent  <= 1'b1;
         end
      end
   end

   //---------------------------------------------------------------------------
   // AXI payloads come straight from the line register so they stay stable
   // for as long as the matching valid is high
   //---------------------------------------------------------------------------
   assign wb_axi3_awid_o    = w_awid;
   assign wb_axi3_awaddr_o  = {r_line_addr, 5'b0_0000};
   assign wb_axi3_awlen_o   = AXI_LEN_SINGLE;
   assign wb_axi3_awsize_o  = AXI_SIZE_32B;
   assign wb_axi3_awburst_o = AXI_BURST_INCR;
   assign wb_axi3_wid_o     = w_awid;
   assign wb_axi3_wdata_o   = r_data;
   assign wb_axi3_wstrb_o   = r_strb;
   assign wb_axi3_wlast_o   = 1'b1;

`ifdef BANK_WB_RESP_CHECK_EN
   logic r_err;
   logic w_unused_offset;

   // The beat offset travels on its own port; the copy in set_way_offset is
   // redundant.
   assign w_unused_offset = sc_wb_set_way_offset_i[0];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_err <= 1'b0;
      end else if ((r_state == WB_RESP) && wb_axi3_bvalid_i &&
                   ((wb_axi3_bresp_i != AXI_RESP_OKAY) || (wb_axi3_bid_i != w_awid))) begin
         r_err <= 1'b1;
      end
   end

   assign wb_err_o = r_err;
`else
   logic w_unused_resp;

   // Response fields are only inspected when response checking is built
   assign w_unused_resp = ^{wb_axi3_bid_i, wb_axi3_bresp_i, sc_wb_set_way_offset_i[0]};
   assign wb_err_o      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bank_wb_buffer.sv
//------------------------------------------------------------------------------
// Module      : tb_bank_wb_buffer
// Description : Self-checking bench for bank_wb_buffer. Directed scenarios
//               followed by randomized transactions; expected AW/W payloads
//               are pushed to a scoreboard and checked by a monitor.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bank_wb_buffer;

   typedef struct {
      logic [31:0]  addr;
      logic [7:0]   id;
      logic [255:0] data;
      logic [31:0]  strb;
   } txn_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Stimulus
   logic         htu_awvalid, sc_valid, sc_off, sc_all;
   logic [26:0]  htu_awaddr;
   logic [5:0]   htu_sw;
   logic [127:0] sc_data;
   logic [6:0]   sc_swo;
   logic         m_awready, m_wready, m_bvalid, auto_slave;
   logic [1:0]   m_bresp;
   logic [7:0]   m_bid;
   logic         r_awr, r_wr, r_bv;

   // DUT outputs
   logic         htu_awready_o, sc_ready_o, awvalid_o, wvalid_o, wlast_o, bready_o, err_o;
   logic [7:0]   awid_o, wid_o;
   logic [31:0]  awaddr_o, wstrb_o;
   logic [3:0]   awlen_o;
   logic [2:0]   awsize_o;
   logic [1:0]   awburst_o;
   logic [255:0] wdata_o;

   // Slave-side inputs: directed values or a randomized responder
   logic         awready, wready, bvalid;
   logic [7:0]   bid;
   logic [1:0]   bresp;
   assign awready = auto_slave ? r_awr : m_awready;
   assign wready  = auto_slave ? r_wr  : m_wready;
   assign bvalid  = auto_slave ? (bready_o & r_bv) : m_bvalid;
   assign bid     = auto_slave ? awid_o : m_bid;
   assign bresp   = auto_slave ? 2'b00 : m_bresp;

   always @(posedge clk) begin
      #1;
      r_awr = 1'($urandom % 2);
      r_wr  = 1'($urandom % 2);
      r_bv  = 1'($urandom % 2);
   end

   bank_wb_buffer dut (
      .clk_i                  (clk),
      .rst_i                  (rst),
      .htu_wb_awvalid_i       (htu_awvalid),
      .htu_wb_awready_o       (htu_awready_o),
      .htu_wb_awaddr_i        (htu_awaddr),
      .htu_wb_set_way_i       (htu_sw),
      .sc_wb_valid_i          (sc_valid),
      .sc_wb_ready_o          (sc_ready_o),
      .sc_wb_data_i           (sc_data),
      .sc_wb_offset_i         (sc_off),
      .sc_wb_all_offset_i     (sc_all),
      .sc_wb_set_way_offset_i (sc_swo),
      .wb_axi3_awvalid_o      (awvalid_o),
      .wb_axi3_awready_i      (awready),
      .wb_axi3_awid_o         (awid_o),
      .wb_axi3_awaddr_o       (awaddr_o),
      .wb_axi3_awlen_o        (awlen_o),
      .wb_axi3_awsize_o       (awsize_o),
      .wb_axi3_awburst_o      (awburst_o),
      .wb_axi3_wvalid_o       (wvalid_o),
      .wb_axi3_wready_i       (wready),
      .wb_axi3_wid_o          (wid_o),
      .wb_axi3_wdata_o        (wdata_o),
      .wb_axi3_wstrb_o        (wstrb_o),
      .wb_axi3_wlast_o        (wlast_o),
      .wb_axi3_bvalid_i       (bvalid),
      .wb_axi3_bready_o       (bready_o),
      .wb_axi3_bid_i          (bid),
      .wb_axi3_bresp_i        (bresp),
      .wb_err_o               (err_o)
   );

   int   n_chk  = 0;
   int   n_fail = 0;
   int   b_cnt  = 0;
   logic exp_err;
   txn_t exp_aw_q[$];
   txn_t exp_w_q[$];

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", nm, act, exp);
      end
   endtask

   task automatic timeout(input string nm);
      n_chk++;
      n_fail++;
      $display("FAIL %s: actual timeout required handshake", nm);
   endtask

   function automatic logic [255:0] byte_mask(input logic [31:0] s);
      logic [255:0] m;
      for (int i = 0; i < 32; i++) m[i*8 +: 8] = {8{s[i]}};
      return m;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   //---------------------------------------------------------------------------
   // Monitor: pops the scoreboard on every AW/W handshake, checks payload
   // stability under backpressure and response ordering.
   //---------------------------------------------------------------------------
   logic         aw_pend, w_pend, aw_done, w_done;
   logic [39:0]  prev_aw;
   logic [255:0] prev_wdata;
   logic [7:0]   cur_id;

   always @(negedge clk) begin
      txn_t t;
      if (rst) begin
         aw_pend = 1'b0; w_pend = 1'b0; aw_done = 1'b0; w_done = 1'b0;
         exp_err = 1'b0;
      end else begin
         if (aw_pend && awvalid_o) chk("aw_stable", {awid_o, awaddr_o}, prev_aw);
         if (w_pend && wvalid_o)   chk("w_stable", wdata_o, prev_wdata);
         if (awvalid_o && awready) begin
            if (exp_aw_q.size() == 0) timeout("unexpected_aw");
            else begin
               t = exp_aw_q.pop_front();
               chk("awaddr", awaddr_o, t.addr);
               chk("awid", awid_o, t.id);
               chk("aw_len_size_burst", {awlen_o, awsize_o, awburst_o}, {4'b0000, 3'b101, 2'b01});
               cur_id  = t.id;
               aw_done = 1'b1;
            end
         end
         if (wvalid_o && wready) begin
            if (exp_w_q.size() == 0) timeout("unexpected_w");
            else begin
               t = exp_w_q.pop_front();
               chk("wdata", wdata_o & byte_mask(t.strb), t.data & byte_mask(t.strb));
               chk("wstrb", wstrb_o, t.strb);
               chk("wid_wlast", {wid_o, wlast_o}, {t.id, 1'b1});
               w_done = 1'b1;
            end
         end
         if (bvalid && bready_o) begin
            chk("b_after_aw_w", {aw_done, w_done}, 2'b11);
            aw_done = 1'b0;
            w_done  = 1'b0;
            b_cnt++;
`ifdef BANK_WB_RESP_CHECK_EN
            if (bresp != 2'b00 || bid != cur_id) exp_err = 1'b1;
`endif
         end
         aw_pend    = awvalid_o && !awready;
         w_pend     = wvalid_o && !wready;
         prev_aw    = {awid_o, awaddr_o};
         prev_wdata = wdata_o;
      end
   end

   //---------------------------------------------------------------------------
   // Drivers (entered and left at posedge+1)
   //---------------------------------------------------------------------------
   task automatic push_txn(input txn_t t);
      exp_aw_q.push_back(t);
      exp_w_q.push_back(t);
   endtask

   task automatic htu_req(input logic [31:0] a, input logic [5:0] sw);
      bit ok = 0;
      htu_awvalid = 1'b1; htu_awaddr = a[31:5]; htu_sw = sw;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (htu_awready_o) begin ok = 1; break; end
      end
      if (!ok) timeout("htu_req");
      @(posedge clk); #1 htu_awvalid = 1'b0;
   endtask

   task automatic sc_beat(input logic [127:0] d, input logic o, input logic a, input logic [5:0] sw);
      bit ok = 0;
      sc_valid = 1'b1; sc_data = d; sc_off = o; sc_all = a; sc_swo = {sw, o};
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (sc_ready_o) begin ok = 1; break; end
      end
      if (!ok) timeout("sc_beat");
      @(posedge clk); #1 sc_valid = 1'b0;
   endtask

   task automatic resp(input logic [7:0] id, input logic [1:0] r);
      bit ok = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (bready_o) begin ok = 1; break; end
      end
      if (!ok) timeout("wait_bready");
      @(posedge clk); #1 m_bvalid = 1'b1; m_bid = id; m_bresp = r;
      @(posedge clk); #1 m_bvalid = 1'b0; m_bresp = 2'b00;
   endtask

   // Random transaction: the expected line is built from the beats with the
   // rule "last beat to a half wins, each written half gets 16 strobes".
   task automatic run_random();
      txn_t         t;
      logic [5:0]   sw = 6'($urandom);
      logic         all = 1'($urandom % 2);
      logic         f = 1'($urandom % 2);
      logic [127:0] bd[3];
      logic         bo[3];
      int           nb;
      if (!all) begin nb = 1; bo[0] = f; end
      else if ($urandom % 2) begin nb = 2; bo[0] = f; bo[1] = ~f; end
      else begin nb = 3; bo[0] = f; bo[1] = f; bo[2] = ~f; end
      t.addr = $urandom & 32'hFFFF_FFE0;
      t.id   = {2'b00, sw};
      t.data = '0;
      t.strb = '0;
      for (int k = 0; k < nb; k++) begin
         bd[k] = rnd128();
         if (bo[k]) begin t.data[255:128] = bd[k]; t.strb[31:16] = 16'hFFFF; end
         else       begin t.data[127:0]   = bd[k]; t.strb[15:0]  = 16'hFFFF; end
      end
      push_txn(t);
      htu_req(t.addr, sw);
      for (int k = 0; k < nb; k++) sc_beat(bd[k], bo[k], all, sw);
      repeat ($urandom % 3) begin @(posedge clk); #1; end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual no finish required finish");
      $fatal(1, "watchdog");
   end

   //---------------------------------------------------------------------------
   // Main sequence
   //---------------------------------------------------------------------------
   initial begin
      txn_t         t;
      logic [127:0] da, db;
      int           b_start;
      bit           ok;

      rst = 1'b0;
      htu_awvalid = 0; htu_awaddr = '0; htu_sw = '0;
      sc_valid = 0; sc_data = '0; sc_off = 0; sc_all = 0; sc_swo = '0;
      m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 2'b00; m_bid = '0;
      auto_slave = 0;
      #2 rst = 1'b1;

      // Reset state
      @(negedge clk);
      chk("rst_htu_awready", htu_awready_o, 1'b1);
      chk("rst_valids", {sc_ready_o, awvalid_o, wvalid_o, bready_o, err_o}, 5'b0);
      chk("rst_awaddr_awid", {awid_o, awaddr_o}, 40'h0);
      chk("rst_wdata", wdata_o, 256'h0);
      chk("rst_wstrb", wstrb_o, 32'h0);
      @(posedge clk); #1 rst = 1'b0;

      // Full line, minimum latency
      da = rnd128(); db = rnd128();
      t.addr = 32'h1234_5660; t.id = 8'h2A; t.data = {db, da}; t.strb = 32'hFFFF_FFFF;
      push_txn(t);
      htu_awvalid = 1; htu_awaddr = 27'h091A2B3; htu_sw = 6'h2A;
      @(negedge clk) chk("c0_htu_awready", htu_awready_o, 1'b1);
      @(posedge clk); #1 htu_awvalid = 0;
      sc_valid = 1; sc_data = da; sc_off = 0; sc_all = 1; sc_swo = {6'h2A, 1'b0};
      @(negedge clk);
      chk("c1_sc_ready", sc_ready_o, 1'b1);
      chk("c1_htu_awready", htu_awready_o, 1'b0);
      @(posedge clk); #1 sc_data = db; sc_off = 1; sc_swo = {6'h2A, 1'b1};
      @(negedge clk);
      chk("c2_sc_ready", sc_ready_o, 1'b1);
      chk("c2_awvalid", awvalid_o, 1'b0);
      @(posedge clk); #1 sc_valid = 0; m_awready = 1; m_wready = 1;
      @(negedge clk) chk("c3_aw_w_valid", {awvalid_o, wvalid_o}, 2'b11);
      @(posedge clk); #1 m_awready = 0; m_wready = 0; m_bvalid = 1; m_bid = 8'h2A; m_bresp = 2'b00;
      @(negedge clk) chk("c4_bready_awv_htu", {bready_o, awvalid_o, htu_awready_o}, 3'b100);
      @(posedge clk); #1 m_bvalid = 0;
      @(negedge clk) chk("c5_idle", {htu_awready_o, bready_o}, 2'b10);
      @(posedge clk); #1;

      // Partial high half
      m_awready = 1; m_wready = 1;
      da = rnd128();
      t.addr = 32'h0000_ABC0; t.id = 8'h05; t.data = {da, 128'h0}; t.strb = 32'hFFFF_0000;
      push_txn(t);
      htu_req(t.addr, 6'h05);
      sc_beat(da, 1'b1, 1'b0, 6'h05);
      resp(8'h05, 2'b00);

      // Mismatched set/way is stalled, then the matching beat is accepted
      da = rnd128();
      t.addr = 32'h7654_3200; t.id = 8'h10; t.data = {128'h0, da}; t.strb = 32'h0000_FFFF;
      push_txn(t);
      htu_req(t.addr, 6'h10);
      sc_valid = 1; sc_data = rnd128(); sc_off = 0; sc_all = 0; sc_swo = {6'h11, 1'b0};
      @(negedge clk) chk("mismatch_ready_a", sc_ready_o, 1'b0);
      @(posedge clk); #1;
      @(negedge clk) chk("mismatch_ready_b", sc_ready_o, 1'b0);
      @(posedge clk); #1 sc_swo = {6'h10, 1'b0}; sc_data = da;
      @(negedge clk) chk("match_ready", sc_ready_o, 1'b1);
      @(posedge clk); #1 sc_valid = 0;
      resp(8'h10, 2'b00);

      // AW backpressure with W accepted immediately
      m_awready = 0; m_wready = 1;
      da = rnd128(); db = rnd128();
      t.addr = 32'hCAFE_0020; t.id = 8'h33; t.data = {db, da}; t.strb = 32'hFFFF_FFFF;
      push_txn(t);
      htu_req(t.addr, 6'h33);
      sc_beat(db, 1'b1, 1'b1, 6'h33);
      sc_beat(da, 1'b0, 1'b1, 6'h33);
      @(negedge clk) chk("bp_c1_aw_w", {awvalid_o, wvalid_o}, 2'b11);
      @(posedge clk); #1;
      @(negedge clk) chk("bp_c2_aw_w", {awvalid_o, wvalid_o}, 2'b10);
      @(posedge clk); #1;
      @(negedge clk) chk("bp_c3_aw_bready", {awvalid_o, bready_o}, 2'b10);
      @(posedge clk); #1 m_awready = 1;
      @(negedge clk) chk("bp_c4_aw_bready", {awvalid_o, bready_o}, 2'b10);
      @(posedge clk); #1 m_awready = 0;
      @(negedge clk) chk("bp_resp", {awvalid_o, bready_o}, 2'b01);
      resp(8'h33, 2'b00);

      // HTU request during RESP, then reset while in SEND
      m_awready = 1; m_wready = 1;
      da = rnd128();
      t.addr = 32'h0101_0100; t.id = 8'h07; t.data = {128'h0, da}; t.strb = 32'h0000_FFFF;
      push_txn(t);
      htu_req(t.addr, 6'h07);
      sc_beat(da, 1'b0, 1'b0, 6'h07);
      ok = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bready_o) begin ok = 1; break; end
      end
      if (!ok) timeout("resp_wait");
      @(posedge clk); #1 htu_awvalid = 1; htu_awaddr = 27'h0000123; htu_sw = 6'h08;
      @(negedge clk) chk("resp_htu_block_a", htu_awready_o, 1'b0);
      @(posedge clk); #1 m_bvalid = 1; m_bid = 8'h07; m_bresp = 2'b00;
      @(negedge clk) chk("resp_htu_block_b", htu_awready_o, 1'b0);
      @(posedge clk); #1 m_bvalid = 0;
      @(negedge clk) chk("after_b_htu_awready", htu_awready_o, 1'b1);
      @(posedge clk); #1 htu_awvalid = 0; m_awready = 0; m_wready = 0;
      sc_beat(rnd128(), 1'b0, 1'b0, 6'h08);
      @(negedge clk) chk("pre_rst_send", {awvalid_o, wvalid_o}, 2'b11);
      #1 rst = 1'b1;
      #1 chk("async_rst_outputs", {awvalid_o, wvalid_o, bready_o, htu_awready_o}, 4'b0001);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Error response followed by an OKAY transaction
      m_awready = 1; m_wready = 1;
      da = rnd128();
      t.addr = 32'h0BAD_0040; t.id = 8'h0C; t.data = {da, 128'h0}; t.strb = 32'hFFFF_0000;
      push_txn(t);
      htu_req(t.addr, 6'h0C);
      sc_beat(da, 1'b1, 1'b0, 6'h0C);
      resp(8'h0C, 2'b10);
      @(negedge clk) chk("err_after_slverr", err_o, exp_err);
      @(posedge clk); #1;
      da = rnd128();
      t.addr = 32'h0600_0060; t.id = 8'h0D; t.data = {128'h0, da}; t.strb = 32'h0000_FFFF;
      push_txn(t);
      htu_req(t.addr, 6'h0D);
      sc_beat(da, 1'b0, 1'b0, 6'h0D);
      resp(8'h0D, 2'b00);
      @(negedge clk) chk("err_sticky", err_o, exp_err);
      @(posedge clk); #1;

      // Randomized traffic with a randomized AXI responder
      auto_slave = 1;
      b_start = b_cnt;
      for (int n = 0; n < 40; n++) run_random();
      ok = 0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (b_cnt == b_start + 40) begin ok = 1; break; end
      end
      if (!ok) timeout("random_drain");
      chk("scoreboard_empty", 32'(exp_aw_q.size() + exp_w_q.size()), 32'd0);
      chk("err_final", err_o, exp_err);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/bank_wb_buffer.md
Name: bank_wb_buffer

Overview:
- Single-line writeback/eviction buffer on the bank write path.
- Accepts a write request (line address, set/way) from the HTU and collects one or two 128-bit halves of that line from the SRAM controller (sc).
- Issues one AXI3 single-beat AW+W transaction of DATA_WIDTH bits and holds until the B response returns.
- Feeds the AW/W/B channels of the bank bus interface.

Parameters:
- ADDR_WIDTH, 32: byte address width.
- DATA_WIDTH, 256: line/bus width; the half width is DATA_WIDTH/2, which is 128.
- STRB_WIDTH, DATA_WIDTH/8: write strobe width.
- ID_WIDTH, 8: AXI ID width; must be at least 6.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- htu_wb_awvalid_i  in  1  write request valid
- htu_wb_awready_o  out  1  request accepted
- htu_wb_awaddr_i  in  ADDR_WIDTH-5  line address [ADDR_WIDTH-1:5]
- htu_wb_set_way_i  in  6  set/way tag of the line
- sc_wb_valid_i  in  1  half-line data valid
- sc_wb_ready_o  out  1  half-line accepted
- sc_wb_data_i  in  128  half-line data
- sc_wb_offset_i  in  1  0 = low half [127:0], 1 = high half [255:128]
- sc_wb_all_offset_i  in  1  1 = both halves will be sent; 0 = only this half is dirty
- sc_wb_set_way_offset_i  in  7  {set_way[5:0], offset}
- wb_axi3_awvalid_o / wb_axi3_awready_i  out/in  1  AW handshake
- wb_axi3_awid_o  out  ID_WIDTH  {zeros, set_way}
- wb_axi3_awaddr_o  out  ADDR_WIDTH  {line addr, 5'b0}
- wb_axi3_awlen_o  out  4  always 4'b0000
- wb_axi3_awsize_o  out  3  always 3'b101
- wb_axi3_awburst_o  out  2  always 2'b01
- wb_axi3_wvalid_o / wb_axi3_wready_i  out/in  1  W handshake
- wb_axi3_wid_o  out  ID_WIDTH  same as awid
- wb_axi3_wdata_o  out  DATA_WIDTH  assembled line
- wb_axi3_wstrb_o  out  STRB_WIDTH  byte strobes
- wb_axi3_wlast_o  out  1  always 1
- wb_axi3_bvalid_i / wb_axi3_bready_o  in/out  1  B handshake
- wb_axi3_bid_i  in  ID_WIDTH  response ID
- wb_axi3_bresp_i  in  2  response code
- wb_err_o  out  1  sticky response error (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk_i; rst_i is asynchronous, active-high.
- FSM states: IDLE, FILL, SEND, RESP. Reset forces IDLE and clears all registers.
- Reset values of outputs:
  - htu_wb_awready_o = 1 (it is the IDLE decode).
  - sc_wb_ready_o = 0, awvalid = 0, wvalid = 0, bready = 0, wb_err_o = 0.
  - Address, ID, data and strobe outputs = 0.
- IDLE:
  - htu_wb_awready_o = 1.
  - On awvalid&&awready: latch address and set_way, clear the strobe register, go to FILL.
- FILL:
  - sc_wb_ready_o = sc_wb_valid_i && (sc_wb_set_way_offset_i[6:1] == latched set_way). Non-matching beats are stalled, not dropped.
  - On an accepted beat:
    - Write the data into the half selected by offset and set that half's 16 strobe bits.
    - Latch all_offset from the first beat.
    - A repeated offset overwrites the stored half.
  - Transition to SEND on the cycle after:
    - an accepted beat with all_offset=0, or
    - the accepted beat that completes both halves when all_offset=1.
- SEND:
  - awvalid and wvalid are asserted together from the first SEND cycle.
  - Each deasserts independently after its own handshake; sent flags are tracked.
  - Go to RESP when both handshakes are done; both may complete in the same cycle.
  - Payloads are stable while valid is high.
- RESP:
  - bready = 1. On bvalid: go to IDLE, and awready is high the next cycle.
  - bid is not compared unless the optional feature is enabled.
- Latency, minimum for a full line: HTU handshake at cycle 0, beats at cycles 1 and 2, AW/W valid at cycle 3, B may be accepted at cycle 4 at the earliest.
- Only one outstanding transaction. A new HTU request is back-pressured until RESP completes.
- wstrb: all ones for a full line; 0x0000FFFF for the low half only; 0xFFFF0000 for the high half only.
- Reset mid-operation: the transaction is abandoned and valids drop immediately. No bus recovery; the system resets the interconnect together with this block.

Optional Feature:
- Macro: BANK_WB_RESP_CHECK_EN.
- Defined: in RESP, the block sets sticky wb_err_o when bresp != 2'b00 or bid != the issued awid. Only reset clears it.
- Undefined: wb_err_o is tied to 0 and no compare logic is built.

Decomposition:
- Shared package bank_pkg holds the constants AXI_SIZE_32B = 3'b101, AXI_BURST_INCR = 2'b01 and AXI_RESP_OKAY = 2'b00, plus the wb FSM state enum.
- No sub-module is needed. The 2x128 line register with strobes is inline logic.

Test Plan:
- Full line: HTU addr 0x1234_5660 (line 0x91A2B3), set_way 0x2A, beats offset0 data A then offset1 data B, all_offset=1 -> awaddr 0x1234_5660, awid 0x2A, wdata {B,A}, wstrb all ones, AW/W valid at cycle 3, returns to IDLE after bvalid.
- Partial high half: set_way 0x05, single beat offset1 with all_offset=0 -> wstrb 0xFFFF0000, wdata[255:128] equals the beat.
- Mismatched set_way: beat with set_way_offset {0x11,0} while latched 0x10 -> sc_wb_ready_o = 0 and the beat is held; matching beat then accepted.
- AXI backpressure: awready held 0 for 3 cycles while wready=1 at once -> wvalid drops after 1 cycle, awvalid holds 4 cycles with a stable payload, RESP is entered only after both handshakes.
- HTU request during RESP -> awready = 0 until the cycle after the B handshake. Reset asserted in SEND -> all valids 0 asynchronously and awready = 1.
- BANK_WB_RESP_CHECK_EN defined: bresp = 2'b10 -> wb_err_o = 1 and it stays 1 through a subsequent OKAY transaction.
